// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared constants for the BCD display scanner: nibble width, active-low
// segment patterns ({g,f,e,d,c,b,a}, 0 = segment lit) and the digit table.
// No ports.
// -----------------------------------------------------------------------------
package display_pkg;

    localparam int unsigned BCD_W = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Index n holds the active-low pattern for decimal digit n (0..9).
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

endpackage

// File: rtl/seven_seg_decoder.sv
// -----------------------------------------------------------------------------
// seven_seg_decoder
// Combinational BCD nibble to active-low 7-segment pattern. Nibbles 10..15
// are not valid BCD and are shown as a dash.
// Ports:
//   nibble  in  [3:0]  BCD digit value
//   pattern out [6:0]  {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module seven_seg_decoder
    import display_pkg::*;
(
    input  logic [BCD_W-1:0] nibble,
    output logic [6:0]       pattern
);

    always_comb begin
        pattern = SEG_DASH;
        if (nibble <= 4'd9) begin
            pattern = SEG_DIGITS[nibble];
        end
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// -----------------------------------------------------------------------------
// bcd_display_scanner
// Latches packed BCD words from the encoder into a pending buffer and commits
// them to the display register only at a frame boundary, so one refresh frame
// never mixes two conversions. Digits are time-multiplexed onto a common-anode
// display with registered active-low segment/anode outputs.
//
// Optional feature: define BCD_SCANNER_LZB_EN for leading-zero blanking.
//
// Parameters:
//   DIGITS       number of digits (>=1), digit 0 least significant
//   REFRESH_DIV  clock cycles per digit slot (>=2)
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   synchronous active-high reset
//   BCD_data   in   [DIGITS*4-1:0] packed BCD, digit k at [4k+3:4k]
//   BCD_ready  in   one-cycle strobe qualifying BCD_data
//   seg        out  [6:0] {g,f,e,d,c,b,a}, active-low
//   dp         out  decimal point, active-low, always off
//   anode      out  [DIGITS-1:0] one-hot-low digit enable
// -----------------------------------------------------------------------------
module bcd_display_scanner
    import display_pkg::*;
#(
    parameter int unsigned DIGITS      = 8,
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DIGITS*BCD_W-1:0] BCD_data,
    input  logic                    BCD_ready,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [DIGITS-1:0]       anode
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] INDEX_LAST = IW'(DIGITS - 1);

`ifdef BCD_SCANNER_LZB_EN
    // Reset shows value 0: everything above digit 0 is a leading zero.
    localparam logic [DIGITS-1:0] MASK_RST = ~DIGITS'(1);
`else
    localparam logic [DIGITS-1:0] MASK_RST = '0;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0]                   prescaler, prescaler_next;
    logic [IW-1:0]                   index, index_next;
    logic [DIGITS-1:0][BCD_W-1:0]    pending, pending_next;
    logic                            pending_valid, pending_valid_next;
    logic [DIGITS-1:0][BCD_W-1:0]    display, display_next;
    logic [DIGITS-1:0]               blank_mask, blank_mask_next;
    logic [6:0]                      seg_reg, seg_next;
    logic [DIGITS-1:0]               anode_reg, anode_next;

    // ------------------------------------------------------------------
    // Internal combinational signals
    // ------------------------------------------------------------------
    logic                            wrap;
    logic                            frame_end;
    logic                            commit;
    logic [DIGITS-1:0][BCD_W-1:0]    commit_word;
    logic [DIGITS-1:0]               commit_mask;
    logic [BCD_W-1:0]                cur_digit;
    logic [6:0]                      cur_pattern;

    // ------------------------------------------------------------------
    // Refresh timing: prescaler and digit index
    // ------------------------------------------------------------------
    always_comb begin
        wrap      = (prescaler == PRESC_LAST);
        frame_end = wrap && (index == INDEX_LAST);

        prescaler_next = wrap ? '0 : prescaler + PW'(1);

        index_next = index;
        if (wrap) begin
            index_next = (index == INDEX_LAST) ? '0 : index + IW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Capture / commit
    // A strobe landing on the frame boundary bypasses pending and commits
    // directly; the older pending word is dropped.
    // ------------------------------------------------------------------
    always_comb begin
        commit_word = BCD_ready ? BCD_data : pending;
        commit      = frame_end && (BCD_ready || pending_valid);
    end

`ifdef BCD_SCANNER_LZB_EN
    logic nonzero_above;

    // Walk down from the top digit; a digit is blanked while every digit at
    // or above it is zero. Dash nibbles (10..15) count as non-zero.
    always_comb begin
        commit_mask   = '0;
        nonzero_above = 1'b0;
        for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
            nonzero_above  = nonzero_above | (commit_word[k] != '0);
            commit_mask[k] = ~nonzero_above;
        end
    end
`else
    always_comb begin
        commit_mask = '0;
    end
`endif

    always_comb begin
        pending_next       = pending;
        pending_valid_next = pending_valid;
        display_next       = display;
        blank_mask_next    = blank_mask;

        if (commit) begin
            display_next       = commit_word;
            blank_mask_next    = commit_mask;
            pending_valid_next = 1'b0;
        end else if (BCD_ready) begin
            // Last strobe wins while nothing has been committed yet.
            pending_next       = BCD_data;
            pending_valid_next = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Digit decode and output selection
    // ------------------------------------------------------------------
    always_comb begin
        cur_digit = display[index];
    end

    seven_seg_decoder u_decoder (
        .nibble  (cur_digit),
        .pattern (cur_pattern)
    );

    always_comb begin
        seg_next   = blank_mask[index] ? SEG_BLANK : cur_pattern;
        anode_next = ~(DIGITS'(1) << index);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            prescaler     <= '0;
            index         <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
            display       <= '0;
            blank_mask    <= MASK_RST;
            seg_reg       <= SEG_BLANK;
            anode_reg     <= '1;
        end else begin
            prescaler     <= prescaler_next;
            index         <= index_next;
            pending       <= pending_next;
            pending_valid <= pending_valid_next;
            display       <= display_next;
            blank_mask    <= blank_mask_next;
            seg_reg       <= seg_next;
            anode_reg     <= anode_next;
        end
    end

    assign seg   = seg_reg;
    assign anode = anode_reg;
    assign dp    = 1'b1;

endmodule
